// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frames -> E0/F0-decoded key events -> show-ahead event FIFO.
// Latency: event visible two clk edges after the stop-bit sample; pin edge to accepted fall is 2+FILTER_LEN.
// Backpressure: ev_ready stalls the FIFO; a push into a full FIFO with no pop is dropped and sets overflow.
module ps2_key_event_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 12000,
    parameter int CNT_W      = 12
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [CNT_W-1:0]              key_count,
    output logic [7:0]                    held_code,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_NONE  = 8'hFF;

    // ------------------------------------------------------------------
    // Input synchroniser and ps2_clk glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk) begin
        if (clrn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN
    // consecutive cycles of disagreement; fall pulses on an accepted 1->0.
    always_ff @(posedge clk) begin
        if (clrn) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_sync[1];
                    filt_cnt <= '0;
                    fall     <= clk_filt;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: bit counter 0..10 with shift register and timeout
    // ------------------------------------------------------------------
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [9:0]    shreg, shreg_nxt;     // [0]=start, [8:1]=data, [9]=parity once full
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic          frame_good;
    logic          frame_bad;

    // State register for the frame receiver.
    always_ff @(posedge clk) begin
        if (clrn) begin
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
        end else begin
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    // Next state: shift a bit per fall, wrap after the stop bit, abandon a
    // stalled partial frame once the timeout expires.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        to_cnt_nxt  = to_cnt;
        if (fall) begin
            to_cnt_nxt = '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt_nxt = '0;
            end else begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                shreg_nxt   = {dat_sync[1], shreg[9:1]};
            end
        end else if (bit_cnt != 4'd0) begin
            if (to_cnt == TW'(TIMEOUT - 1)) begin
                bit_cnt_nxt = '0;
                to_cnt_nxt  = '0;
            end else begin
                to_cnt_nxt = to_cnt + 1'b1;
            end
        end else begin
            to_cnt_nxt = '0;
        end
    end

    // Frame verdict at the stop-bit sample: start low, stop high, odd parity.
    always_comb begin
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (fall && bit_cnt == 4'd10) begin
            if (!shreg[0] && dat_sync[1] && (^shreg[9:1])) begin
                frame_good = 1'b1;
            end else begin
                frame_bad = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte hand-off and prefix decoder
    // ------------------------------------------------------------------
    logic       byte_vld;
    logic [7:0] byte_dat;
    logic       ext_pend;
    logic       brk_pend;
    logic       evt_vld;
    logic [9:0] evt_dat;                 // {ext, break, code}

    // Register the received byte (or the error pulse) one edge after the stop bit.
    always_ff @(posedge clk) begin
        if (clrn) begin
            byte_vld  <= 1'b0;
            byte_dat  <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= frame_good;
            byte_dat  <= shreg[8:1];
            frame_err <= frame_bad;
        end
    end

    // E0/F0 set pending flags in any order; any other byte completes an event.
    always_ff @(posedge clk) begin
        if (clrn) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            evt_vld  <= 1'b0;
            evt_dat  <= '0;
        end else begin
            evt_vld <= 1'b0;
            if (byte_vld) begin
                if (byte_dat == CODE_EXT) begin
                    ext_pend <= 1'b1;
                end else if (byte_dat == CODE_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    evt_vld  <= 1'b1;
                    evt_dat  <= {ext_pend, brk_pend, byte_dat};
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Held key and new-keystroke counter
    // ------------------------------------------------------------------
    logic held_ext;
    logic held_match;

    assign held_match = (held_code != CODE_NONE) &&
                        ({held_ext, held_code} == {evt_dat[9], evt_dat[7:0]});

    // A make of the already-held key is a typematic repeat and is not counted;
    // only a break of the held key clears it.
    always_ff @(posedge clk) begin
        if (clrn) begin
            held_code <= CODE_NONE;
            held_ext  <= 1'b0;
            key_count <= '0;
        end else if (evt_vld) begin
            if (!evt_dat[8]) begin
                if (!held_match) begin
                    held_code <= evt_dat[7:0];
                    held_ext  <= evt_dat[9];
                    key_count <= key_count + 1'b1;
                end
            end else if (held_match) begin
                held_code <= CODE_NONE;
                held_ext  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [9:0]    head;

    assign fifo_full = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign ev_valid  = (fifo_level != '0);
    assign pop       = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = evt_vld && (!fifo_full || pop);
    assign head      = mem[rd_ptr];
    assign ev_ext    = ev_valid ? head[9]   : 1'b0;
    assign ev_break  = ev_valid ? head[8]   : 1'b0;
    assign ev_code   = ev_valid ? head[7:0] : 8'h00;

    // Storage write; contents need no reset since the outputs are gated by ev_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= evt_dat;
        end
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (evt_vld && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed plus randomized bench for ps2_key_event_rx against a byte-level reference model.
// Latency: frames take ~440 clk cycles each; events are checked after each frame settles.
// Backpressure: ev_ready is driven per scenario to exercise stall, overflow and simultaneous push/pop.
module tb_ps2_key_event_rx;

    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
    localparam int TOUT  = 200;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          clrn = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          ev_ready = 1'b0;
    logic          ev_valid;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_break;
    logic [CW-1:0] key_count;
    logic [7:0]    held_code;
    logic          overflow;
    logic          frame_err;
    logic [3:0]    fifo_level;

    ps2_key_event_rx #(
        .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(FLEN),
        .TIMEOUT   (TOUT),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .key_count (key_count),
        .held_code (held_code),
        .overflow  (overflow),
        .frame_err (frame_err),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int lat = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [7:0] pool [4] = '{8'h1C, 8'h75, 8'h29, 8'h5A};

    // Reference model state: prefix flags, held key, keystroke count, FIFO occupancy.
    logic m_ext, m_brk, m_held_vld, m_ready, m_ovf;
    logic [8:0] m_held;
    int m_count, m_level;

    // Collect every popped event and every frame_err pulse, away from the clock edge.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) got_q.push_back({ev_ext, ev_break, ev_code});
        if (frame_err) ferr_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held_vld = 0; m_held = '0;
        m_count = 0; m_level = 0; m_ovf = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Byte-level decoding rules, applied to each correctly framed byte.
    task automatic model_byte(input logic [7:0] b);
        logic [9:0] ev;
        logic [8:0] key;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            ev  = {m_ext, m_brk, b};
            key = {m_ext, b};
            if (m_ready) exp_q.push_back(ev);
            else if (m_level < DEPTH) begin exp_q.push_back(ev); m_level++; end
            else m_ovf = 1;
            if (!m_brk) begin
                if (!(m_held_vld && m_held == key)) begin
                    m_count++; m_held = key; m_held_vld = 1;
                end
            end else if (m_held_vld && m_held == key) begin
                m_held_vld = 0;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    function automatic logic [7:0] m_held_code();
        return m_held_vld ? m_held[7:0] : 8'hFF;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    // Drive the first nbits bits; ps2_clk is left low after the last falling edge.
    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            if (i != nbits - 1) begin
                wait_clk(20);
                ps2_clk = 1'b1;
                wait_clk(10);
            end
        end
    endtask

    task automatic release_clk();
        wait_clk(20);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(make_frame(b, bad), 11);
        release_clk();
        if (!bad) model_byte(b);
    endtask

    task automatic compare_events(input string tag);
        wait_clk(30);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_ev"}, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_keycnt"}, {20'd0, key_count}, m_count & 32'hFFF);
        chk({tag, "_held"}, {24'd0, held_code}, {24'd0, m_held_code()});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, ev_valid, 0);
        chk({tag, "_code"}, ev_code, 0);
        chk({tag, "_ext"}, ev_ext, 0);
        chk({tag, "_brk"}, ev_break, 0);
        chk({tag, "_keycnt"}, key_count, 0);
        chk({tag, "_held"}, held_code, 8'hFF);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_level"}, fifo_level, 0);
    endtask

    task automatic do_reset();
        clrn = 1'b1;
        wait_clk(3);
        clrn = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  code;
        logic        ext, brk;

        // Reset values
        m_ready = 1;
        wait_clk(3);
        check_reset_vals("rst");
        clrn = 1'b0;
        model_reset();
        wait_clk(5);

        // Make/break of A, measuring stop-bit-fall to ev_valid latency on the way
        ev_ready = 1'b1;
        send_bits(make_frame(8'h1C, 1'b0), 11);
        lat = 0;
        while (!ev_valid && lat < 100) begin wait_clk(1); lat++; end
        chk("first_event_seen", lat < 100, 1);
        release_clk();
        model_byte(8'h1C);
        check_state("a_make");
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        check_state("a_break");
        compare_events("a");

        // Extended key make, then E0 F0 break
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        check_state("ext_make");
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
        check_state("ext_break");
        compare_events("ext");

        // Typematic repeats of A then release
        for (int i = 0; i < 3; i++) send_byte(8'h1C, 0);
        check_state("typematic");
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        check_state("typematic_rel");
        compare_events("typematic");

        // FIFO fill, simultaneous push/pop while full, then overflow drop
        do_reset();
        ev_ready = 1'b0; m_ready = 0;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 0);
        chk("full_level", fifo_level, DEPTH);
        chk("full_no_ovf", overflow, 0);
        chk("full_head", ev_code, 8'h10);
        send_bits(make_frame(8'h18, 1'b0), 11);
        wait_clk(lat - 1);
        ev_ready = 1'b1;
        wait_clk(1);
        ev_ready = 1'b0;
        release_clk();
        m_level--;
        model_byte(8'h18);
        chk("pushpop_level", fifo_level, m_level);
        chk("pushpop_no_ovf", overflow, m_ovf);
        chk("pushpop_one_pop", got_q.size(), 1);
        send_byte(8'h19, 0);
        chk("drop_level", fifo_level, DEPTH);
        chk("drop_ovf", overflow, m_ovf);
        ev_ready = 1'b1; m_ready = 1; m_level = 0;
        compare_events("drain");
        chk("drain_level", fifo_level, 0);
        chk("drain_ovf_sticky", overflow, 1);
        check_state("drain");

        // Bad parity frame, then a 1-cycle ps2_clk glitch before a good frame
        ferr_seen = 0;
        send_byte(8'h5A, 1);
        chk("badpar_ferr", ferr_seen, 1);
        compare_events("badpar");
        ps2_clk = 1'b0;
        wait_clk(1);
        ps2_clk = 1'b1;
        wait_clk(20);
        send_byte(8'h5A, 0);
        chk("glitch_no_ferr", ferr_seen, 1);
        compare_events("glitch");

        // Partial frame abandoned by timeout, then a full frame
        send_bits(make_frame(8'h29, 1'b0), 5);
        release_clk();
        wait_clk(TOUT + 100);
        send_byte(8'h29, 0);
        chk("timeout_no_ferr", ferr_seen, 1);
        compare_events("timeout");
        check_state("timeout");

        // Reset in the middle of a frame with an event pending in the FIFO
        do_reset();
        ev_ready = 1'b0; m_ready = 0;
        send_byte(8'h1C, 0);
        chk("pend_valid", ev_valid, 1);
        chk("pend_code", ev_code, 8'h1C);
        check_state("pend");
        send_bits(make_frame(8'h33, 1'b0), 5);
        clrn = 1'b1;
        wait_clk(2);
        check_reset_vals("midrst");
        ps2_clk = 1'b1; ps2_data = 1'b1;
        clrn = 1'b0;
        model_reset();
        wait_clk(20);
        ev_ready = 1'b1; m_ready = 1;
        send_byte(8'h29, 0);
        check_state("after_rst");
        compare_events("after_rst");

        // Randomized key sequences against the model
        for (int n = 0; n < 20; n++) begin
            if (m_held_vld && $urandom_range(0, 2) == 0) begin
                brk = 1; ext = m_held[8]; code = m_held[7:0];
            end else begin
                code = pool[$urandom_range(0, 3)];
                ext  = 1'($urandom_range(0, 1));
                brk  = ($urandom_range(0, 3) == 0);
            end
            if (ext && brk && $urandom_range(0, 1) == 1) begin
                send_byte(8'hF0, 0); send_byte(8'hE0, 0);
            end else begin
                if (ext) send_byte(8'hE0, 0);
                if (brk) send_byte(8'hF0, 0);
            end
            send_byte(code, 0);
            check_state("rand");
        end
        compare_events("rand");
        chk("rand_no_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver: it deserialises device-to-host frames and decodes E0/F0 prefixes into complete key events. Events are buffered in a configurable FIFO and drained through a valid/ready handshake. It also keeps a new-keystroke counter with typematic-repeat suppression and a held-key register. It sits between the PS/2 pins and the game/display logic, replacing the single-byte keyboard front end.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of 2, ≥2
- FILTER_LEN, 4, clk cycles ps2_clk must be stable before a level change is accepted; ≥1
- TIMEOUT, 12000, clk cycles without an accepted ps2_clk falling edge before a partial frame is discarded
- CNT_W, 12, width of key_count
- clk  in  1  system clock; one clock
- clrn  in  1  reset, synchronous and active-high (1 = reset)
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  8  scan code of the head event
- ev_ext  out  1  head event was E0-prefixed
- ev_break  out  1  head event is a release (F0-prefixed)
- key_count  out  CNT_W  count of new (non-repeat) make events; wraps
- held_code  out  8  code of the most recent unreleased make; 8'hFF when none
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse: frame rejected
- fifo_level  out  log2(FIFO_DEPTH)+1  entries in FIFO

## Operation
- Input path: 2-FF synchroniser on ps2_clk and ps2_data. Glitch filter: filtered ps2_clk changes only after the synchronised value has differed from it for FILTER_LEN consecutive cycles. `fall` is a one-cycle pulse on a filtered 1→0 transition.
- Frame FSM (bit counter 0..10): each `fall` samples synchronised ps2_data into bit[count]. At count 10, check start==0, stop==1 and odd parity over data+parity.
  - Pass: the data byte goes to the decoder.
  - Fail: frame_err pulses; the byte is discarded.
  - Either way, the counter returns to 0.
- Timeout: a counter clears on each `fall`. When count≠0 and TIMEOUT cycles pass without a `fall`, the bit counter returns to 0 silently (no frame_err).
- Decoder:
  - 8'hE0 sets ext_pend.
  - 8'hF0 sets brk_pend.
  - Any other byte forms the event {ext_pend, brk_pend, byte} and clears both flags.
  - E0 F0 xx and F0 after E0 are both legal, in either prefix order.
- Repeat suppression: a make event whose {ext, code} equals the held key is a typematic repeat. It is still pushed to the FIFO but does not increment key_count.
- Held-key register:
  - A new make sets held_code/held_ext and increments key_count.
  - A break matching held {ext, code} sets held_code=8'hFF.
  - A break not matching the held key leaves held_code unchanged.
- FIFO: 10-bit entries {ext, break, code}, show-ahead; head is always driven on ev_*.
  - Pop when ev_valid && ev_ready.
  - Push when full and no pop: event dropped, overflow set. overflow is cleared only by reset.
  - Push and pop in the same cycle while full: both take effect, level unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (clrn=1 at a clk edge) clears FSM, prefix flags, timeout counter, FIFO pointers, key_count and overflow, and sets held_code=8'hFF. A partially received frame is discarded.
- Reset values: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, key_count=0, held_code=8'hFF, overflow=0, frame_err=0, fifo_level=0.

## Timing
- Edge T is the clk edge at which the stop bit is sampled.
  - T+1: byte registered into the decoder; frame_err pulses in the cycle after T on failure.
  - T+2: event written. With the FIFO previously empty, ev_valid=1 and key_count/held_code are updated in the same cycle.
  - Prefix bytes produce no event.
- Pop: head advances at the edge where ev_valid && ev_ready. The next entry is visible in the following cycle; ev_valid stays high if level>1.
- Accepted `fall` lags the raw pin edge by 2+FILTER_LEN clk cycles.
- Throughput: one event per frame. The FIFO absorbs bursts while the consumer stalls ev_ready.

## Test plan
- Frame 8'h1C (A) with valid parity, then F0 1C → events {0,0,1C} then {0,1,1C}; key_count=1; held_code 1C then FF.
- E0 F0 75 after E0 75 → events {1,0,75} and {1,1,75}; key_count=1; held_code FF at end.
- 1C sent three times (typematic) then F0 1C → 4 events; key_count=1.
- ev_ready=0, 9 make events with FIFO_DEPTH=8 → fifo_level=8, overflow=1, 9th event absent. Then drain in order with a pop on the cycle of a new push while full → no loss and no new overflow.
- Bad parity frame → frame_err pulse, no event. A 1-cycle ps2_clk glitch with FILTER_LEN=4 → no bit sampled.
- Send 5 bits, then idle > TIMEOUT, then a full 8'h29 frame → single event {0,0,29}. Assert clrn mid-frame → all outputs return to reset values and the next full frame decodes correctly.
